// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter and its users.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } fm_state_e;

  localparam int GATE_1S_50MHZ = 50000000;
  localparam int DEFAULT_CNT_W = 32;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous input and emits a one-cycle pulse on each rising edge.
// Total latency from input change to pulse is SYNC_STAGES+1 cycles.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic fin,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   rise_r;

  // Synchronizer chain, history bit and registered rise pulse
  always_ff @(posedge fin or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      prev_r <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
      prev_r <= sync_r[SYNC_STAGES-1];
      rise_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
    end
  end

  assign rise_pulse = rise_r;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a gate window of GATE_CYCLES fin cycles.
// Build option: define FREQ_METER_SAT_EN for a saturating edge counter with overflow flag.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_1S_50MHZ,
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             fin,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic             freq_valid,
  output logic [CNT_W-1:0] freq_count,
  output logic             ovf
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  fm_state_e         state_r, state_nxt_s;
  logic [GATE_W-1:0] gate_cnt_r;
  logic [CNT_W-1:0]  edge_cnt_r, edge_nxt_s, freq_count_r;
  logic              ovf_int_r, ovf_nxt_s, ovf_r;
  logic              busy_r, freq_valid_r;
  logic              rise_s, clear_s;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .fin        (fin),
    .rst_n      (rst_n),
    .async_in   (sig_in),
    .rise_pulse (rise_s)
  );

  // Next-state logic; clear_s marks every entry into a fresh window
  always_comb begin
    state_nxt_s = state_r;
    clear_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = GATE;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GATE: begin
        if (gate_cnt_r == GATE_LAST) begin
          state_nxt_s = LATCH;
        end else begin
          state_nxt_s = GATE;
        end
      end
      LATCH: begin
        if (continuous) begin
          state_nxt_s = GATE;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Edge counter next value, including an edge in the final gate cycle
  always_comb begin
    edge_nxt_s = edge_cnt_r;
    ovf_nxt_s  = ovf_int_r;
    if ((state_r == GATE) && rise_s) begin
`ifdef FREQ_METER_SAT_EN
      if (&edge_cnt_r) begin
        ovf_nxt_s = 1'b1;
      end else begin
        edge_nxt_s = edge_cnt_r + CNT_W'(1'b1);
      end
`else
      edge_nxt_s = edge_cnt_r + CNT_W'(1'b1);
`endif
    end else begin
      edge_nxt_s = edge_cnt_r;
    end
  end

  // State register and window counters; gate counter holds at its last value
  always_ff @(posedge fin or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      gate_cnt_r <= '0;
      edge_cnt_r <= '0;
      ovf_int_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (clear_s) begin
        gate_cnt_r <= '0;
        edge_cnt_r <= '0;
        ovf_int_r  <= 1'b0;
      end else if (state_r == GATE) begin
        if (gate_cnt_r != GATE_LAST) begin
          gate_cnt_r <= gate_cnt_r + GATE_W'(1'b1);
        end else begin
          gate_cnt_r <= gate_cnt_r;
        end
        edge_cnt_r <= edge_nxt_s;
        ovf_int_r  <= ovf_nxt_s;
      end else begin
        gate_cnt_r <= gate_cnt_r;
        edge_cnt_r <= edge_cnt_r;
        ovf_int_r  <= ovf_int_r;
      end
    end
  end

  // Result registers load on the GATE->LATCH edge so they are visible during LATCH
  always_ff @(posedge fin or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      freq_valid_r <= 1'b0;
      freq_count_r <= '0;
      ovf_r        <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      if ((state_r == GATE) && (state_nxt_s == LATCH)) begin
        freq_valid_r <= 1'b1;
        freq_count_r <= edge_nxt_s;
`ifdef FREQ_METER_SAT_EN
        ovf_r        <= ovf_nxt_s;
`else
        ovf_r        <= 1'b0;
`endif
      end else begin
        freq_valid_r <= 1'b0;
      end
    end
  end

  assign busy       = busy_r;
  assign freq_valid = freq_valid_r;
  assign freq_count = freq_count_r;
  assign ovf        = ovf_r;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: vector table, scoreboard queues, corner sequences.
module tb_freq_meter;

  localparam int GC = 100;

`ifdef FREQ_METER_SAT_EN
  localparam logic [31:0] OVF_CNT  = 32'd15;
  localparam logic        OVF_FLAG = 1'b1;
`else
  localparam logic [31:0] OVF_CNT  = 32'd2;
  localparam logic        OVF_FLAG = 1'b0;
`endif

  typedef struct {
    logic [31:0] cnt;
    logic        ovf;
    int          when;
  } exp_t;

  typedef struct {
    string       name;
    int          period;
    logic        dc;
    logic [31:0] exp_cnt;
  } vec_t;

  logic        fin = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_in = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, continuous = 1'b0;
  logic        busy_a, valid_a, ovf_a, busy_b, valid_b, ovf_b;
  logic [31:0] count_a;
  logic [3:0]  count_b;

  int   cyc = 0;
  int   total = 0, bad = 0;
  int   period = 2;
  logic dc_lvl = 1'b0;
  int   ph = 0;
  int   ks;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  vec_t vecs[6];

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(32), .SYNC_STAGES(2)) dut_a (
    .fin(fin), .rst_n(rst_n), .sig_in(sig_in), .start(start_a), .continuous(continuous),
    .busy(busy_a), .freq_valid(valid_a), .freq_count(count_a), .ovf(ovf_a)
  );

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
    .fin(fin), .rst_n(rst_n), .sig_in(sig_in), .start(start_b), .continuous(1'b0),
    .busy(busy_b), .freq_valid(valid_b), .freq_count(count_b), .ovf(ovf_b)
  );

  always #5 fin = ~fin;
  always @(posedge fin) cyc <= cyc + 1;

  // sig_in pattern: period 0 means DC at dc_lvl, else high for period/2 cycles
  initial begin
    forever begin
      @(negedge fin);
      if (period == 0) begin
        sig_in = dc_lvl;
      end else begin
        ph = (ph + 1) % period;
        sig_in = (ph < period / 2);
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge fin);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && (qa.size() + qb.size()) > 0; i++) @(negedge fin);
    if ((qa.size() + qb.size()) > 0) begin
      check("drain_timeout", 64'(qa.size() + qb.size()), 64'd0);
      qa.delete();
      qb.delete();
    end
  endtask

  // Scoreboard for the 32-bit instance
  always @(negedge fin) begin
    if (valid_a) begin
      if (qa.size() == 0) begin
        check("a_unexpected_valid", 64'd1, 64'd0);
      end else begin
        ea = qa.pop_front();
        check("a_count", count_a, ea.cnt);
        check("a_ovf", ovf_a, ea.ovf);
        check("a_time", cyc, ea.when);
      end
    end
  end

  // Scoreboard for the 4-bit instance
  always @(negedge fin) begin
    if (valid_b) begin
      if (qb.size() == 0) begin
        check("b_unexpected_valid", 64'd1, 64'd0);
      end else begin
        eb = qb.pop_front();
        check("b_count", count_b, eb.cnt);
        check("b_ovf", ovf_b, eb.ovf);
        check("b_time", cyc, eb.when);
      end
    end
  end

  initial begin
    vecs[0] = '{"period10", 10, 1'b0, 32'd10};
    vecs[1] = '{"period4",   4, 1'b0, 32'd25};
    vecs[2] = '{"maxrate",   2, 1'b0, 32'd50};
    vecs[3] = '{"period5",   5, 1'b0, 32'd20};
    vecs[4] = '{"dc_high",   0, 1'b1, 32'd0};
    vecs[5] = '{"dc_low",    0, 1'b0, 32'd0};

    // Reset held with sig_in toggling
    repeat (6) @(negedge fin);
    check("rst_busy", busy_a, 64'd0);
    check("rst_valid", valid_a, 64'd0);
    check("rst_ovf", ovf_a, 64'd0);
    check("rst_count", count_a, 64'd0);
    check("rst_count_b", count_b, 64'd0);
    rst_n = 1'b1;

    // Single-shot windows, with a start re-pulse mid-window that must be ignored
    foreach (vecs[v]) begin
      period = vecs[v].period;
      dc_lvl = vecs[v].dc;
      repeat (12) @(negedge fin);
      ks = cyc;
      start_a = 1'b1;
      qa.push_back('{vecs[v].exp_cnt, 1'b0, ks + GC + 1});
      check({vecs[v].name, "_busy_pre"}, busy_a, 64'd0);
      @(negedge fin);
      start_a = 1'b0;
      check({vecs[v].name, "_busy_first"}, busy_a, 64'd1);
      wait_cyc(ks + 50);
      start_a = 1'b1;
      @(negedge fin);
      start_a = 1'b0;
      wait_cyc(ks + GC + 1);
      check({vecs[v].name, "_busy_latch"}, busy_a, 64'd1);
      @(negedge fin);
      check({vecs[v].name, "_busy_after"}, busy_a, 64'd0);
      wait_drain(200);
    end

    // Continuous mode, dropped mid third window
    continuous = 1'b1;
    period = 4;
    repeat (12) @(negedge fin);
    ks = cyc;
    start_a = 1'b1;
    for (int w = 1; w <= 3; w++) qa.push_back('{32'd25, 1'b0, ks + w * (GC + 1)});
    @(negedge fin);
    start_a = 1'b0;
    wait_cyc(ks + 250);
    continuous = 1'b0;
    wait_cyc(ks + 3 * (GC + 1) + 1);
    check("cont_busy_end", busy_a, 64'd0);
    wait_drain(50);
    repeat (150) @(negedge fin);

    // Overflow behaviour on the 4-bit instance, then a clean window
    period = 2;
    repeat (12) @(negedge fin);
    ks = cyc;
    start_b = 1'b1;
    qb.push_back('{OVF_CNT, OVF_FLAG, ks + GC + 1});
    @(negedge fin);
    start_b = 1'b0;
    wait_drain(300);
    period = 0;
    dc_lvl = 1'b0;
    repeat (12) @(negedge fin);
    ks = cyc;
    start_b = 1'b1;
    qb.push_back('{32'd0, 1'b0, ks + GC + 1});
    @(negedge fin);
    start_b = 1'b0;
    wait_drain(300);

    // Reset asserted mid-window: outputs clear at once and no result follows
    period = 4;
    repeat (12) @(negedge fin);
    ks = cyc;
    start_a = 1'b1;
    qa.push_back('{32'd25, 1'b0, ks + GC + 1});
    @(negedge fin);
    start_a = 1'b0;
    wait_cyc(ks + 40);
    rst_n = 1'b0;
    #1;
    qa.delete();
    check("midrst_busy", busy_a, 64'd0);
    check("midrst_valid", valid_a, 64'd0);
    check("midrst_count", count_a, 64'd0);
    check("midrst_ovf", ovf_a, 64'd0);
    repeat (2) @(negedge fin);
    rst_n = 1'b1;
    repeat (150) @(negedge fin);
    check("midrst_idle", busy_a, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of a slow external or derived signal (for example a divided 1 Hz tick or a sensor pulse train) by counting its rising edges over a fixed gate window of system clocks.
- Sits downstream of the clock dividers in the traffic-light and board designs.
- Used to self-check divider outputs and to feed a 7-seg display path with a count.
- Single-shot or continuous measurement, with a done pulse and a held result.

Parameters:
- GATE_CYCLES, 50000000, gate window length in fin cycles (1 s at 50 MHz); must be >= 2.
- CNT_W, 32, width of the edge counter and of freq_count.
- SYNC_STAGES, 2, flip-flop depth of the sig_in synchronizer; must be >= 2.

Ports:
- fin  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sig_in  input  1  asynchronous signal to be measured.
- start  input  1  level-sampled request to begin a measurement; honoured only in IDLE.
- continuous  input  1  when high, a new window starts automatically after each result.
- busy  output  1  high in GATE and LATCH states.
- freq_valid  output  1  one-cycle pulse when freq_count updates.
- freq_count  output  CNT_W  rising edges counted in the last completed window; held until the next result.
- ovf  output  1  overflow flag for the last window (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - Synchronizer, edge-detect history, gate counter and edge counter clear to 0.
  - busy, freq_valid and ovf are 0, and freq_count is 0.
  - Reset may assert mid-window; the partial count is discarded and no freq_valid is issued.
- Edge detect:
  - sig_in passes through SYNC_STAGES flops.
  - A rise is detected when the synchronized value is 1 and its previous value was 0; this produces a one-cycle pulse.
  - Maximum measurable rate is fin/2, with high and low each lasting >= 1 cycle.
  - Detection latency is SYNC_STAGES+1 cycles. This latency is common to both window ends, so it does not bias the count.
- FSM states are IDLE, GATE and LATCH.
  - IDLE: if start is high at edge k, go to GATE. The gate counter and edge counter clear to 0 and ovf_int clears.
  - GATE: lasts exactly GATE_CYCLES cycles (k+1 .. k+GATE_CYCLES).
    - The gate counter increments every cycle.
    - The edge counter increments on each detect pulse that occurs during a GATE cycle, including the final one.
    - When gate_cnt equals GATE_CYCLES-1, go to LATCH.
  - LATCH: occupies cycle k+GATE_CYCLES+1.
    - freq_count takes the edge counter value, ovf takes ovf_int, and freq_valid is 1 for this one cycle.
    - Next state is GATE (counters cleared) if continuous is high, otherwise IDLE.
    - Edges detected in the LATCH cycle are dropped. Consecutive windows are GATE_CYCLES+1 cycles apart.
- start during GATE or LATCH is ignored and is not queued.
- Deasserting continuous mid-window lets the current window finish, report, and then return to IDLE.
- start and continuous may both be high in IDLE; this starts continuous operation.
- The gate counter is $clog2(GATE_CYCLES) bits wide, unsigned, and never wraps.

Optional Feature:
- Macro: FREQ_METER_SAT_EN.
- Defined:
  - The edge counter saturates at all-ones instead of incrementing.
  - ovf_int is set sticky for the window on any increment attempted at all-ones.
  - ovf reports ovf_int in LATCH.
- Undefined:
  - The edge counter wraps modulo 2^CNT_W.
  - ovf is tied to 0.
  - The port remains present in both builds.

Decomposition:
- Package freq_meter_pkg holds:
  - the state enum (IDLE, GATE, LATCH);
  - the constant GATE_1S_50MHZ = 50000000;
  - the default CNT_W.
- One sub-module is natural: sync_edge_det.
  - Parameter: SYNC_STAGES.
  - Ports: fin, rst_n, async_in, rise_pulse.
  - Reusable by other blocks in the codebase, such as push-button and sensor inputs.

Test Plan (GATE_CYCLES=100, SYNC_STAGES=2 unless noted):
- Reset → hold rst_n low with sig_in toggling → busy=0, freq_valid=0, ovf=0, freq_count=0; assert rst_n mid-GATE → same values immediately, no freq_valid afterward.
- Single shot → sig_in period 10 cycles (5 high / 5 low), start pulse at cycle k → freq_valid only at k+101, freq_count=10, busy high k+1..k+101; start re-pulsed at k+50 → ignored.
- DC input → sig_in held high from before start → freq_count=0 at k+101.
- Continuous → continuous=1, sig_in period 4 → freq_valid at k+101, k+202, k+303, each with freq_count=25; drop continuous at k+250 → last pulse at k+303, then IDLE, busy=0.
- Max rate → sig_in period 2 (fin/2) → freq_count=50.
- Overflow (CNT_W=4, sig_in period 2):
  - FREQ_METER_SAT_EN defined → freq_count=15, ovf=1.
  - Undefined → freq_count=2 (50 mod 16), ovf=0.
  - Next window with sig_in low → ovf=0.
